// File: rtl/mem_read_sched.sv
// ---------------------------------------------------------------------------
// mem_read_sched
// Read scheduler for the per-BX memory pages that feed the output data mux.
// When the bunch-crossing number changes, the entry counts of the BX just
// finished are snapshotted (clamped to one page), and the pages are drained
// one read per clock, lowest memory index first. After the last read a single
// end-of-BX marker (select 4'b1111) is issued. A BX change that arrives
// before the marker aborts the drain and pulses o_bx_trunc.
//
// Ports
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_bx        current bunch-crossing number
//   i_nent      entry counts, memory i at [i*NENT_W +: NENT_W]
//   o_rd_en     one-hot read enable, bit i reads memory i
//   o_rd_addr   {rd_bx, entry index}, shared by all memories
//   o_sel       binary mux select, delayed RD_LAT clocks to meet read data
//   o_rd_bx     BX currently being drained
//   o_bx_trunc  one-clock pulse: drain aborted by a new BX
//
// All outputs come straight from flops. The issue registers are loaded one
// clock ahead from the "next" view of the scheduler state, so a read shows
// up on o_rd_en in the clock right after the BX-change edge.
// ---------------------------------------------------------------------------
module mem_read_sched #(
   parameter int NMEM   = 12,
   parameter int ADDR_W = 6,
   parameter int NENT_W = 7,
   parameter int RD_LAT = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [2:0]             i_bx,
   input  logic [NMEM*NENT_W-1:0] i_nent,
   output logic [NMEM-1:0]        o_rd_en,
   output logic [ADDR_W+2:0]      o_rd_addr,
   output logic [3:0]             o_sel,
   output logic [2:0]             o_rd_bx,
   output logic                   o_bx_trunc
);

   localparam int                CNT_W    = ADDR_W + 1;
   localparam logic [NENT_W-1:0] MAX_NENT = NENT_W'(2**ADDR_W);
   localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(2**ADDR_W);
   localparam logic [3:0]        SEL_IDLE = 4'b0000;
   localparam logic [3:0]        SEL_MARK = 4'b1111;

   typedef enum logic {ST_IDLE = 1'b0, ST_READ = 1'b1} state_t;

   // Memory index to mux select code; 4'b1010 and 4'b1110 are skipped.
   function automatic logic [3:0] enc_sel(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:    code = 4'b0001;
         4'd1:    code = 4'b0010;
         4'd2:    code = 4'b0011;
         4'd3:    code = 4'b0100;
         4'd4:    code = 4'b0101;
         4'd5:    code = 4'b0110;
         4'd6:    code = 4'b0111;
         4'd7:    code = 4'b1000;
         4'd8:    code = 4'b1001;
         4'd9:    code = 4'b1011;
         4'd10:   code = 4'b1100;
         4'd11:   code = 4'b1101;
         default: code = SEL_IDLE;
      endcase
      return code;
   endfunction

   // Counts larger than one page are clamped to a full page.
   function automatic logic [CNT_W-1:0] clamp_cnt(input logic [NENT_W-1:0] n);
      logic [CNT_W-1:0] c;
      if (n > MAX_NENT) begin
         c = MAX_CNT;
      end else begin
         c = n[CNT_W-1:0];
      end
      return c;
   endfunction

   // Scheduler state (values valid in the current clock)
   state_t              r_state;
   logic [2:0]          r_bx_q;
   logic [2:0]          r_rd_bx;
   logic [CNT_W-1:0]    r_snap [NMEM];
   logic [CNT_W-1:0]    r_cnt  [NMEM];   // reads issued before this clock
   // Issue registers (what is driven this clock)
   logic [NMEM-1:0]     r_rd_en;
   logic [ADDR_W+2:0]   r_rd_addr;
   logic [3:0]          r_sel_iss;
   logic                r_mark;
   logic                r_bx_trunc;
   logic [3:0]          r_sel_pipe [RD_LAT];

   // Next-clock view
   logic                w_chg;
   state_t              w_state_nxt;
   logic [2:0]          w_rd_bx_nxt;
   logic                w_trunc_nxt;
   logic [CNT_W-1:0]    w_snap_nxt [NMEM];
   logic [CNT_W-1:0]    w_cnt_nxt  [NMEM];
   logic [NMEM-1:0]     w_pend;
   logic                w_pick_ok;
   logic [3:0]          w_pick_idx;
   logic [ADDR_W-1:0]   w_pick_ent;
   logic [NMEM-1:0]     w_rd_en_nxt;
   logic [ADDR_W+2:0]   w_rd_addr_nxt;
   logic [3:0]          w_sel_nxt;
   logic                w_mark_nxt;

   // Next state: a BX change restarts the drain from a fresh snapshot;
   // otherwise counters advance by the read issued this clock.
   always_comb begin
      w_chg       = (i_bx != r_bx_q);
      w_state_nxt = r_state;
      w_rd_bx_nxt = r_rd_bx;
      w_trunc_nxt = 1'b0;
      for (int i = 0; i < NMEM; i++) begin
         w_snap_nxt[i] = r_snap[i];
         w_cnt_nxt[i]  = r_cnt[i] + {{(CNT_W-1){1'b0}}, r_rd_en[i]};
      end
      if (w_chg) begin
         w_state_nxt = ST_READ;
         w_rd_bx_nxt = r_bx_q;
         // Aborted only if this clock still carries a read, not the marker.
         w_trunc_nxt = (r_state == ST_READ) && !r_mark;
         for (int i = 0; i < NMEM; i++) begin
            w_snap_nxt[i] = clamp_cnt(i_nent[i*NENT_W +: NENT_W]);
            w_cnt_nxt[i]  = {CNT_W{1'b0}};
         end
      end else if ((r_state == ST_READ) && r_mark) begin
         w_state_nxt = ST_IDLE;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Issue for the next clock: lowest-index memory with entries left,
   // or the end-of-BX marker once every page is drained.
   always_comb begin
      w_pick_ok     = 1'b0;
      w_pick_idx    = 4'd0;
      w_pick_ent    = {ADDR_W{1'b0}};
      w_rd_en_nxt   = {NMEM{1'b0}};
      w_rd_addr_nxt = {(ADDR_W+3){1'b0}};
      w_sel_nxt     = SEL_IDLE;
      w_mark_nxt    = 1'b0;
      for (int i = 0; i < NMEM; i++) begin
         w_pend[i] = (w_cnt_nxt[i] < w_snap_nxt[i]);
      end
      // Scan downwards so the lowest pending index wins.
      for (int i = NMEM-1; i >= 0; i--) begin
         w_pick_ok  = w_pick_ok | w_pend[i];
         w_pick_idx = w_pend[i] ? 4'(i) : w_pick_idx;
         w_pick_ent = w_pend[i] ? w_cnt_nxt[i][ADDR_W-1:0] : w_pick_ent;
      end
      case (w_state_nxt)
         ST_READ: begin
            if (w_pick_ok) begin
               w_rd_en_nxt   = {{(NMEM-1){1'b0}}, 1'b1} << w_pick_idx;
               w_rd_addr_nxt = {w_rd_bx_nxt, w_pick_ent};
               w_sel_nxt     = enc_sel(w_pick_idx);
               w_mark_nxt    = 1'b0;
            end else begin
               w_rd_en_nxt   = {NMEM{1'b0}};
               w_sel_nxt     = SEL_MARK;
               w_mark_nxt    = 1'b1;
            end
         end
         ST_IDLE: begin
            w_sel_nxt  = SEL_IDLE;
            w_mark_nxt = 1'b0;
         end
         default: begin
            w_sel_nxt  = SEL_IDLE;
            w_mark_nxt = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Snapshot, counters and issue registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bx_q     <= 3'd0;
         r_rd_bx    <= 3'd0;
         r_bx_trunc <= 1'b0;
         r_rd_en    <= {NMEM{1'b0}};
         r_rd_addr  <= {(ADDR_W+3){1'b0}};
         r_sel_iss  <= SEL_IDLE;
         r_mark     <= 1'b0;
         for (int i = 0; i < NMEM; i++) begin
            r_snap[i] <= {CNT_W{1'b0}};
            r_cnt[i]  <= {CNT_W{1'b0}};
         end
      end else begin
         r_bx_q     <= i_bx;
         r_rd_bx    <= w_rd_bx_nxt;
         r_bx_trunc <= w_trunc_nxt;
         r_rd_en    <= w_rd_en_nxt;
         r_rd_addr  <= w_rd_addr_nxt;
         r_sel_iss  <= w_sel_nxt;
         r_mark     <= w_mark_nxt;
         for (int i = 0; i < NMEM; i++) begin
            r_snap[i] <= w_snap_nxt[i];
            r_cnt[i]  <= w_cnt_nxt[i];
         end
      end
   end

   // Select delay line so the select lands with the memory read data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_sel_pipe[i] <= SEL_IDLE;
         end
      end else begin
         r_sel_pipe[0] <= r_sel_iss;
         for (int i = 1; i < RD_LAT; i++) begin
            r_sel_pipe[i] <= r_sel_pipe[i-1];
         end
      end
   end

   assign o_rd_en    = r_rd_en;
   assign o_rd_addr  = r_rd_addr;
   assign o_sel      = r_sel_pipe[RD_LAT-1];
   assign o_rd_bx    = r_rd_bx;
   assign o_bx_trunc = r_bx_trunc;

endmodule
